// File: rtl/gerenciador_ativos_pkg.sv
// Shared definitions for the active-node buffer: widths, infinity constant,
// extraction FSM encoding and the lowest-index priority encoder.
package gerenciador_ativos_pkg;

    localparam int DIST_WIDTH_PADRAO  = 8;
    localparam int NODE_WIDTH_PADRAO  = 8;
    localparam int BUFFER_SIZE_PADRAO = 16;
    localparam int CRIT_WIDTH         = DIST_WIDTH_PADRAO + 1;
    localparam logic [DIST_WIDTH_PADRAO-1:0] DIST_INFINITA = {DIST_WIDTH_PADRAO{1'b1}};

    // Upper bound on slot count that the priority encoder can scan.
    localparam int MAX_SLOTS = 64;

    typedef enum logic {
        OCIOSO = 1'b0,
        EMITIR = 1'b1
    } estado_t;

    // Index of the lowest set bit; 0 when the mask is empty (callers qualify with |mask).
    function automatic int menor_indice(input logic [MAX_SLOTS-1:0] mascara);
        int idx;
        idx = 0;
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (mascara[i]) begin
                idx = i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gerenciador_ativos_seletor_minimo.sv
// Combinational min-reduction tree over N criterion values, ignoring
// inactive entries; reports the minimum and whether any entry was active.
module seletor_minimo #(
    parameter int N = 16,
    parameter int W = 9
) (
    input  logic [N-1:0][W-1:0] criterios_i,
    input  logic [N-1:0]        ativos_i,
    output logic [W-1:0]        minimo_o,
    output logic                algum_ativo_o
);

    localparam int NIVEIS = (N > 1) ? $clog2(N) : 1;
    localparam int P      = 1 << NIVEIS;

    logic [P-1:0][W-1:0]     crit_pad_s;
    logic [P-1:0]            ativos_pad_s;
    logic [2*P-1:1][W-1:0]   valor_s;
    logic [2*P-1:1]          valido_s;

    // Heap-ordered tree: leaves at P+i, node n combines children 2n and 2n+1.
    always_comb begin
        crit_pad_s          = '1;
        ativos_pad_s        = '0;
        crit_pad_s[N-1:0]   = criterios_i;
        ativos_pad_s[N-1:0] = ativos_i;
        valor_s             = '1;
        valido_s            = '0;
        for (int i = 0; i < P; i++) begin
            valor_s[P+i]  = crit_pad_s[i];
            valido_s[P+i] = ativos_pad_s[i];
        end
        for (int n = P - 1; n >= 1; n--) begin
            if (valido_s[2*n] && valido_s[2*n+1]) begin
                valido_s[n] = 1'b1;
                valor_s[n]  = (valor_s[2*n+1] < valor_s[2*n]) ? valor_s[2*n+1] : valor_s[2*n];
            end else if (valido_s[2*n]) begin
                valido_s[n] = 1'b1;
                valor_s[n]  = valor_s[2*n];
            end else if (valido_s[2*n+1]) begin
                valido_s[n] = 1'b1;
                valor_s[n]  = valor_s[2*n+1];
            end else begin
                valido_s[n] = 1'b0;
                valor_s[n]  = '1;
            end
        end
        minimo_o      = valor_s[1];
        algum_ativo_o = valido_s[1];
    end

endmodule

// File: rtl/gerenciador_ativos.sv
// CAM-style buffer of active shortest-path nodes with insert/relax/remove,
// registered settle threshold and a valid/ready extraction of approved nodes.
module gerenciador_ativos
    import gerenciador_ativos_pkg::*;
#(
    parameter int DIST_WIDTH  = DIST_WIDTH_PADRAO,
    parameter int NODE_WIDTH  = NODE_WIDTH_PADRAO,
    parameter int BUFFER_SIZE = BUFFER_SIZE_PADRAO,
    parameter int IDX_WIDTH   = $clog2(BUFFER_SIZE)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  escrever_in,
    output logic                  escrever_pronto_out,
    input  logic [DIST_WIDTH-1:0] ativar_distancia_in,
    input  logic [DIST_WIDTH-1:0] ativar_menor_vizinho_in,
    input  logic [NODE_WIDTH-1:0] ativar_endereco_no_in,
    input  logic                  remover_in,
    input  logic [NODE_WIDTH-1:0] remover_endereco_no_in,
    input  logic                  ler_distancia_in,
    input  logic [NODE_WIDTH-1:0] ler_distancia_endereco_in,
    output logic [DIST_WIDTH-1:0] distancia_out,
    output logic                  distancia_valida_out,
    output logic                  encontrado_out,
    output logic                  tem_ativo_out,
    output logic                  cheio_out,
    output logic [DIST_WIDTH:0]   limiar_out,
    output logic [BUFFER_SIZE-1:0] aprovados_out,
    input  logic                  iniciar_in,
    output logic                  saida_valido_out,
    input  logic                  saida_pronto_in,
    output logic [NODE_WIDTH-1:0] saida_endereco_out,
    output logic [DIST_WIDTH-1:0] saida_distancia_out,
    output logic                  concluido_out
);

    localparam int CW = DIST_WIDTH + 1;

    logic [BUFFER_SIZE-1:0]                 ativo_q, ativo_d;
    logic [BUFFER_SIZE-1:0]                 pend_q, pend_d;
    logic [BUFFER_SIZE-1:0][DIST_WIDTH-1:0] dist_q, dist_d;
    logic [BUFFER_SIZE-1:0][DIST_WIDTH-1:0] mv_q, mv_d;
    logic [BUFFER_SIZE-1:0][NODE_WIDTH-1:0] end_q, end_d;
    estado_t                                estado_q, estado_d;
    logic                                   concluido_q, concluido_d;
    logic [CW-1:0]                          limiar_q, limiar_d;
    logic [BUFFER_SIZE-1:0]                 aprov_q, aprov_d;
    logic [DIST_WIDTH-1:0]                  dout_q, dout_d;
    logic                                   dval_q, dval_d;
    logic                                   enc_q, enc_d;

    logic [BUFFER_SIZE-1:0]         hit_w_s, hit_r_s, hit_l_s, rem_mask_s;
    logic [BUFFER_SIZE-1:0][CW-1:0] crit_s;
    logic [CW-1:0]                  min_s;
    logic                           qualquer_s;
    logic [IDX_WIDTH-1:0]           idx_livre_s, idx_hit_w_s, idx_hit_l_s, idx_emit_s;
    logic                           cheio_s, tem_ativo_s, escrever_pronto_s, escrita_ok_s;

    // Address match per slot and per-slot settle criterion.
    always_comb begin
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            hit_w_s[i] = ativo_q[i] && (end_q[i] == ativar_endereco_no_in);
            hit_r_s[i] = ativo_q[i] && (end_q[i] == remover_endereco_no_in);
            hit_l_s[i] = ativo_q[i] && (end_q[i] == ler_distancia_endereco_in);
            crit_s[i]  = {1'b0, dist_q[i]} + {1'b0, mv_q[i]};
        end
        rem_mask_s        = remover_in ? hit_r_s : '0;
        idx_livre_s       = IDX_WIDTH'(menor_indice(MAX_SLOTS'(~ativo_q)));
        idx_hit_w_s       = IDX_WIDTH'(menor_indice(MAX_SLOTS'(hit_w_s)));
        idx_hit_l_s       = IDX_WIDTH'(menor_indice(MAX_SLOTS'(hit_l_s)));
        idx_emit_s        = IDX_WIDTH'(menor_indice(MAX_SLOTS'(pend_q)));
        cheio_s           = &ativo_q;
        tem_ativo_s       = |ativo_q;
        escrever_pronto_s = (estado_q == OCIOSO) && ((|hit_w_s) || !cheio_s);
        // A same-address remove in the same cycle drops the write.
        escrita_ok_s      = escrever_in && escrever_pronto_s &&
                            !(remover_in && (remover_endereco_no_in == ativar_endereco_no_in));
    end

    seletor_minimo #(
        .N (BUFFER_SIZE),
        .W (CW)
    ) u_seletor (
        .criterios_i   (crit_s),
        .ativos_i      (ativo_q),
        .minimo_o      (min_s),
        .algum_ativo_o (qualquer_s)
    );

    // Buffer update and extraction FSM next state.
    always_comb begin
        ativo_d     = ativo_q;
        dist_d      = dist_q;
        mv_d        = mv_q;
        end_d       = end_q;
        pend_d      = pend_q;
        estado_d    = estado_q;
        concluido_d = 1'b0;

        if (escrita_ok_s && (|hit_w_s)) begin
            if (ativar_distancia_in < dist_q[idx_hit_w_s]) begin
                dist_d[idx_hit_w_s] = ativar_distancia_in;
                mv_d[idx_hit_w_s]   = ativar_menor_vizinho_in;
            end else begin
                dist_d[idx_hit_w_s] = dist_q[idx_hit_w_s];
            end
        end else if (escrita_ok_s) begin
            ativo_d[idx_livre_s] = 1'b1;
            dist_d[idx_livre_s]  = ativar_distancia_in;
            mv_d[idx_livre_s]    = ativar_menor_vizinho_in;
            end_d[idx_livre_s]   = ativar_endereco_no_in;
        end else begin
            ativo_d = ativo_q;
        end

        case (estado_q)
            OCIOSO: begin
                if (iniciar_in && tem_ativo_s) begin
                    pend_d   = aprov_q & ativo_q;
                    estado_d = EMITIR;
                end else if (iniciar_in) begin
                    concluido_d = 1'b1;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            EMITIR: begin
                if (pend_q == '0) begin
                    estado_d    = OCIOSO;
                    concluido_d = 1'b1;
                end else if (saida_pronto_in) begin
                    pend_d[idx_emit_s]  = 1'b0;
                    ativo_d[idx_emit_s] = 1'b0;
                end else begin
                    estado_d = EMITIR;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        ativo_d = ativo_d & ~rem_mask_s;
        pend_d  = pend_d & ~rem_mask_s;
    end

    // Threshold, approved mask and lookup result next state.
    always_comb begin
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            aprov_d[i] = ativo_q[i] && ({1'b0, dist_q[i]} <= min_s);
        end
        limiar_d = qualquer_s ? min_s : {CW{1'b1}};
        if (ler_distancia_in) begin
            dval_d = 1'b1;
            enc_d  = |hit_l_s;
            dout_d = (|hit_l_s) ? dist_q[idx_hit_l_s] : {DIST_WIDTH{1'b1}};
        end else begin
            dval_d = 1'b0;
            enc_d  = enc_q;
            dout_d = dout_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ativo_q     <= '0;
            pend_q      <= '0;
            dist_q      <= '0;
            mv_q        <= '0;
            end_q       <= '0;
            estado_q    <= OCIOSO;
            concluido_q <= 1'b0;
            limiar_q    <= {CW{1'b1}};
            aprov_q     <= '0;
            dout_q      <= '0;
            dval_q      <= 1'b0;
            enc_q       <= 1'b0;
        end else begin
            ativo_q     <= ativo_d;
            pend_q      <= pend_d;
            dist_q      <= dist_d;
            mv_q        <= mv_d;
            end_q       <= end_d;
            estado_q    <= estado_d;
            concluido_q <= concluido_d;
            limiar_q    <= limiar_d;
            aprov_q     <= aprov_d;
            dout_q      <= dout_d;
            dval_q      <= dval_d;
            enc_q       <= enc_d;
        end
    end

    assign escrever_pronto_out  = escrever_pronto_s;
    assign distancia_out        = dout_q;
    assign distancia_valida_out = dval_q;
    assign encontrado_out       = enc_q;
    assign tem_ativo_out        = tem_ativo_s;
    assign cheio_out            = cheio_s;
    assign limiar_out           = limiar_q;
    assign aprovados_out        = aprov_q;
    assign saida_valido_out     = (estado_q == EMITIR) && (|pend_q);
    assign saida_endereco_out   = end_q[idx_emit_s];
    assign saida_distancia_out  = dist_q[idx_emit_s];
    assign concluido_out        = concluido_q;

endmodule

// File: tb/tb_gerenciador_ativos.sv
// Self-checking bench: directed vector table, extraction corner sequences and
// randomized traffic against a slot-level reference model.
module tb_gerenciador_ativos;

    logic        clk, rst_n;
    logic        escrever, escrever_pronto;
    logic [7:0]  a_dist, a_mv, a_end;
    logic        remover;
    logic [7:0]  r_end;
    logic        ler;
    logic [7:0]  l_end;
    logic [7:0]  distancia;
    logic        dist_valida, encontrado, tem_ativo, cheio;
    logic [8:0]  limiar;
    logic [15:0] aprovados;
    logic        iniciar, s_valido, s_pronto;
    logic [7:0]  s_end, s_dist;
    logic        concluido;

    int total = 0;
    int bad   = 0;

    gerenciador_ativos dut (
        .clk_in                    (clk),
        .rst_n_in                  (rst_n),
        .escrever_in               (escrever),
        .escrever_pronto_out       (escrever_pronto),
        .ativar_distancia_in       (a_dist),
        .ativar_menor_vizinho_in   (a_mv),
        .ativar_endereco_no_in     (a_end),
        .remover_in                (remover),
        .remover_endereco_no_in    (r_end),
        .ler_distancia_in          (ler),
        .ler_distancia_endereco_in (l_end),
        .distancia_out             (distancia),
        .distancia_valida_out      (dist_valida),
        .encontrado_out            (encontrado),
        .tem_ativo_out             (tem_ativo),
        .cheio_out                 (cheio),
        .limiar_out                (limiar),
        .aprovados_out             (aprovados),
        .iniciar_in                (iniciar),
        .saida_valido_out          (s_valido),
        .saida_pronto_in           (s_pronto),
        .saida_endereco_out        (s_end),
        .saida_distancia_out       (s_dist),
        .concluido_out             (concluido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        esc;
        logic [7:0]  d, mv, a;
        logic        rem;
        logic [7:0]  ra;
        logic        ld;
        logic [7:0]  la;
        logic        exp_pronto;
        logic        exp_enc;
        logic [7:0]  exp_dist;
        logic [8:0]  exp_lim;
        logic [15:0] exp_apr;
        logic        exp_tem;
    } vet_t;

    vet_t tab[9];

    // Reference model: one entry per slot, allocated lowest-free-first.
    bit  m_act[16];
    int  m_end[16], m_dist[16], m_mv[16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic idle();
        escrever = 1'b0; a_dist = 8'd0; a_mv = 8'd0; a_end = 8'd0;
        remover = 1'b0; r_end = 8'd0; ler = 1'b0; l_end = 8'd0;
        iniciar = 1'b0; s_pronto = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] ad, input logic [7:0] d, input logic [7:0] mv);
        escrever = 1'b1; a_end = ad; a_dist = d; a_mv = mv;
        tick();
        escrever = 1'b0;
    endtask

    int          h, hr, hl, f, lim, seen, cnt;
    bit          full, anyact, w, r, l;
    logic [15:0] apr;
    logic [7:0]  ad, d, mv, ra, la;
    logic [7:0]  emit_q[$];

    initial begin
        idle();
        rst_n = 1'b0;
        #13;
        chk("reset_limiar", limiar, 9'h1FF);
        chk("reset_aprov", aprovados, 16'h0);
        chk("reset_pronto", escrever_pronto, 1'b1);
        chk("reset_valido", s_valido, 1'b0);
        chk("reset_dist", distancia, 8'h0);
        rst_n = 1'b1;
        tick();

        tab[0] = '{1'b1, 8'd10, 8'd3, 8'd5, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0,   9'd13, 16'h0001, 1'b1};
        tab[1] = '{1'b1, 8'd12, 8'd1, 8'd7, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0,   9'd13, 16'h0003, 1'b1};
        tab[2] = '{1'b1, 8'd8,  8'd3, 8'd5, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0,   9'd11, 16'h0001, 1'b1};
        tab[3] = '{1'b1, 8'd9,  8'd0, 8'd5, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0,   9'd11, 16'h0001, 1'b1};
        tab[4] = '{1'b0, 8'd0,  8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd5, 1'b1, 1'b1, 8'd8,   9'd11, 16'h0001, 1'b1};
        tab[5] = '{1'b0, 8'd0,  8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b0, 8'hFF,  9'd11, 16'h0001, 1'b1};
        tab[6] = '{1'b0, 8'd0,  8'd0, 8'd0, 1'b1, 8'd5, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0,   9'd13, 16'h0002, 1'b1};
        tab[7] = '{1'b1, 8'd10, 8'd3, 8'd5, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0,   9'd13, 16'h0003, 1'b1};
        tab[8] = '{1'b1, 8'd1,  8'd1, 8'd9, 1'b1, 8'd9, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0,   9'd13, 16'h0003, 1'b1};

        for (int k = 0; k < 9; k++) begin
            escrever = tab[k].esc; a_dist = tab[k].d; a_mv = tab[k].mv; a_end = tab[k].a;
            remover = tab[k].rem; r_end = tab[k].ra; ler = tab[k].ld; l_end = tab[k].la;
            #1;
            chk($sformatf("tab%0d_pronto", k), escrever_pronto, tab[k].exp_pronto);
            tick();
            if (tab[k].ld) begin
                chk($sformatf("tab%0d_valida", k), dist_valida, 1'b1);
                chk($sformatf("tab%0d_enc", k), encontrado, tab[k].exp_enc);
                chk($sformatf("tab%0d_dist", k), distancia, tab[k].exp_dist);
            end
            idle();
            tick();
            tick();
            chk($sformatf("tab%0d_limiar", k), limiar, tab[k].exp_lim);
            chk($sformatf("tab%0d_aprov", k), aprovados, tab[k].exp_apr);
            chk($sformatf("tab%0d_tem", k), tem_ativo, tab[k].exp_tem);
        end

        // Extraction with consumer stalled for three cycles.
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("ext_valido_stall", s_valido, 1'b1);
            chk("ext_end_stall", s_end, 8'd5);
            chk("ext_dist_stall", s_dist, 8'd10);
            tick();
        end
        s_pronto = 1'b1;
        tick();
        chk("ext_valido_2", s_valido, 1'b1);
        chk("ext_end_2", s_end, 8'd7);
        chk("ext_dist_2", s_dist, 8'd12);
        tick();
        s_pronto = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (seen == 0 && concluido) seen = 1;
            else if (seen == 0) tick();
        end
        chk("ext_concluido", seen, 1);
        chk("ext_tem_vazio", tem_ativo, 1'b0);
        tick();
        chk("ext_pulso_unico", concluido, 1'b0);

        // Remove a pending node mid-extraction; writes are refused meanwhile.
        wr(8'd1, 8'd5, 8'd5);
        wr(8'd2, 8'd6, 8'd9);
        wr(8'd3, 8'd7, 8'd9);
        tick();
        tick();
        chk("rm_aprov", aprovados, 16'h0007);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("rm_primeiro", s_end, 8'd1);
        remover = 1'b1; r_end = 8'd2;
        escrever = 1'b1; a_end = 8'd9; a_dist = 8'd1; a_mv = 8'd1;
        #1;
        chk("rm_escrita_recusada", escrever_pronto, 1'b0);
        tick();
        idle();
        s_pronto = 1'b1;
        seen = 0;
        emit_q.delete();
        for (int c = 0; c < 12; c++) begin
            if (seen == 0) begin
                if (s_valido) emit_q.push_back(s_end);
                tick();
                if (concluido) seen = 1;
            end
        end
        s_pronto = 1'b0;
        chk("rm_concluido", seen, 1);
        chk("rm_qtd", emit_q.size(), 2);
        chk("rm_emit0", (emit_q.size() > 0) ? emit_q[0] : 8'hEE, 8'd1);
        chk("rm_emit1", (emit_q.size() > 1) ? emit_q[1] : 8'hEE, 8'd3);
        chk("rm_tem_vazio", tem_ativo, 1'b0);

        // Randomized insert/relax/remove/lookup traffic against the model.
        for (int s = 0; s < 16; s++) begin
            m_act[s] = 1'b0; m_end[s] = 0; m_dist[s] = 0; m_mv[s] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            w  = ($urandom_range(0, 1) == 1);
            ad = 8'($urandom_range(0, 23));
            d  = 8'($urandom_range(0, 255));
            mv = 8'($urandom_range(0, 255));
            r  = ($urandom_range(0, 3) == 0);
            ra = 8'($urandom_range(0, 23));
            l  = ($urandom_range(0, 1) == 1);
            la = 8'($urandom_range(0, 23));
            escrever = w; a_end = ad; a_dist = d; a_mv = mv;
            remover = r; r_end = ra; ler = l; l_end = la;
            #1;
            h = -1; hr = -1; hl = -1; full = 1'b1; lim = 511;
            for (int s = 0; s < 16; s++) begin
                if (m_act[s]) begin
                    if (m_end[s] == int'(ad)) h = s;
                    if (m_end[s] == int'(ra)) hr = s;
                    if (m_end[s] == int'(la)) hl = s;
                    if (m_dist[s] + m_mv[s] < lim) lim = m_dist[s] + m_mv[s];
                end else begin
                    full = 1'b0;
                end
            end
            for (int s = 0; s < 16; s++) apr[s] = m_act[s] && (m_dist[s] <= lim);
            chk("rnd_pronto", escrever_pronto, (h >= 0) || !full);
            if (w && ((h >= 0) || !full) && !(r && ra == ad)) begin
                if (h >= 0) begin
                    if (int'(d) < m_dist[h]) begin
                        m_dist[h] = d; m_mv[h] = mv;
                    end
                end else begin
                    f = -1;
                    for (int s = 15; s >= 0; s--) if (!m_act[s]) f = s;
                    m_act[f] = 1'b1; m_end[f] = ad; m_dist[f] = d; m_mv[f] = mv;
                end
            end
            if (r && hr >= 0) m_act[hr] = 1'b0;
            tick();
            anyact = 1'b0; cnt = 0;
            for (int s = 0; s < 16; s++) if (m_act[s]) begin anyact = 1'b1; cnt++; end
            chk("rnd_limiar", limiar, lim);
            chk("rnd_aprov", aprovados, apr);
            chk("rnd_tem", tem_ativo, anyact);
            chk("rnd_cheio", cheio, cnt == 16);
            chk("rnd_valida", dist_valida, l);
            if (l) begin
                chk("rnd_enc", encontrado, hl >= 0);
                chk("rnd_dist", distancia, (hl >= 0) ? m_dist[hl] : 255);
            end
        end
        idle();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();

        // Fill every slot, then probe write acceptance when full.
        for (int i = 0; i < 16; i++) wr(8'(100 + i), 8'(20 + i), 8'd1);
        chk("cheio", cheio, 1'b1);
        escrever = 1'b1; a_end = 8'd200; a_dist = 8'd1; a_mv = 8'd1;
        #1;
        chk("cheio_novo_recusado", escrever_pronto, 1'b0);
        a_end = 8'd100; a_dist = 8'd50;
        #1;
        chk("cheio_existente_aceito", escrever_pronto, 1'b1);
        tick();
        idle();
        tick();
        tick();

        // Reset in the middle of an extraction.
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("rst_em_emitir", s_valido, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valido", s_valido, 1'b0);
        chk("rst_limiar", limiar, 9'h1FF);
        chk("rst_aprov", aprovados, 16'h0);
        chk("rst_tem", tem_ativo, 1'b0);
        chk("rst_cheio", cheio, 1'b0);
        chk("rst_pronto", escrever_pronto, 1'b1);
        chk("rst_dist", distancia, 8'h0);
        chk("rst_concluido", concluido, 1'b0);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (concluido) seen = 1;
        end
        chk("rst_sem_pulso", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gerenciador_ativos.md
Name: gerenciador_ativos

Overview:
Parametrised successor to the active-node evaluator in the shortest-path engine. It holds up to BUFFER_SIZE active nodes (distance, least outgoing edge cost, node address) in a small CAM-style buffer, and supports insert, relax and remove operations.
- Each cycle it computes the settle threshold: the minimum over active nodes of distance + least edge.
- It exposes the approved set: active nodes with distance <= threshold.
- A valid/ready extraction FSM streams approved nodes to the expansion stage and settles each one (removes it) as it is emitted.

Parameters:
DIST_WIDTH, 8, distance / edge-cost width
NODE_WIDTH, 8, node address width
BUFFER_SIZE, 16, number of active-node slots
IDX_WIDTH, $clog2(BUFFER_SIZE), slot index width (derived)

Ports:
clk_in  input  1  single clock, rising edge
rst_n_in  input  1  reset, asynchronous, active-low
escrever_in  input  1  insert/relax request
escrever_pronto_out  output  1  write accepted this cycle when high with escrever_in
ativar_distancia_in  input  DIST_WIDTH  tentative distance
ativar_menor_vizinho_in  input  DIST_WIDTH  least outgoing edge cost of node
ativar_endereco_no_in  input  NODE_WIDTH  node address
remover_in  input  1  remove request
remover_endereco_no_in  input  NODE_WIDTH  address to remove
ler_distancia_in  input  1  distance lookup request
ler_distancia_endereco_in  input  NODE_WIDTH  lookup address
distancia_out  output  DIST_WIDTH  lookup result
distancia_valida_out  output  1  lookup result valid
encontrado_out  output  1  lookup hit
tem_ativo_out  output  1  at least one slot active
cheio_out  output  1  all slots active
limiar_out  output  DIST_WIDTH+1  registered threshold
aprovados_out  output  BUFFER_SIZE  registered approved-slot mask
iniciar_in  input  1  start extraction
saida_valido_out  output  1  extracted node valid
saida_pronto_in  input  1  consumer ready
saida_endereco_out  output  NODE_WIDTH  extracted node address
saida_distancia_out  output  DIST_WIDTH  extracted node distance
concluido_out  output  1  one-cycle pulse at end of extraction

Behaviour:
- Reset values: all slots inactive and zeroed, FSM in OCIOSO.
  - limiar_out = all ones; aprovados_out = 0.
  - All valid, pronto and pulse outputs = 0, except escrever_pronto_out = 1.
  - distancia_out = 0.
- Reset may be asserted mid-extraction: it aborts the extraction with no concluido_out pulse.
- Hit definition: a slot is a hit when it is active and its stored address equals the input address. At most one hit exists at any time, by construction.
- escrever_pronto_out = (estado == OCIOSO) && (hit || !cheio_out).
- Accepted write, hit case:
  - If the new distance is strictly less than the stored distance, update the stored distance and menor_vizinho.
  - Otherwise the write has no effect.
- Accepted write, miss case: allocate the lowest-index free slot and set it active.
- Remove:
  - Hit: clear the slot's active bit. Allowed in any state.
  - Miss: ignored.
- Remove and write to the same address in the same cycle: remove wins, the write is dropped, and escrever_pronto_out is still reported.
- Criterion per slot = {1'b0, distancia} + menor_vizinho, width DIST_WIDTH+1, no overflow possible.
- Threshold computation:
  - limiar_out is registered; it is the minimum criterion over active slots, or all ones when no slot is active.
  - aprovados_out is registered: bit i = ativo[i] && ({1'b0, distancia[i]} <= comb_min).
  - Both reflect the buffer state at the previous clock edge (1-cycle latency).
- Lookup: result appears one cycle after ler_distancia_in, with distancia_valida_out high for that single cycle.
  - Hit: encontrado_out = 1 and distancia_out = stored distance.
  - Miss: encontrado_out = 0 and distancia_out = all ones.
- FSM OCIOSO:
  - iniciar_in with tem_ativo_out: snapshot pendentes = aprovados_out & ativo, then go to EMITIR.
  - iniciar_in with no active node: pulse concluido_out and stay in OCIOSO.
- FSM EMITIR:
  - saida_valido_out = 1 while pendentes != 0; the outputs present the lowest-index pending slot.
  - On saida_pronto_in, clear that slot's pending bit and active bit.
  - A remove hitting a pending slot clears both bits.
  - When pendentes == 0, pulse concluido_out for one cycle and return to OCIOSO.
  - An empty snapshot in EMITIR returns to OCIOSO with the pulse.
- Output stability: saida_* must stay stable while valid is high and ready is low, unless a remove kills the presented slot.

Decomposition:
- Shared package holds CRIT_WIDTH = DIST_WIDTH+1, DIST_INFINITA (all ones) and the FSM state encoding (OCIOSO, EMITIR).
- One sub-module, seletor_minimo: a parametrised combinational min-reduction tree over BUFFER_SIZE criterion values with an active mask. Outputs the minimum and an any-active flag.
- The lowest-index priority encoder is a function in the package and is reused for allocation and emission.

Test Plan:
1. Write node 5 (d=10, mv=3), then node 7 (d=12, mv=1) -> limiar_out=13, aprovados_out bits 0 and 1 set, tem_ativo_out=1.
2. Relax node 5 with d=8 -> stored 8, limiar 11; then write node 5 with d=9 -> ignored, lookup of node 5 returns 8 with encontrado_out=1; lookup of node 9 returns 0xFF with encontrado_out=0.
3. Fill 16 distinct nodes -> cheio_out=1; a 17th new address sees escrever_pronto_out=0; a write to an existing address still sees escrever_pronto_out=1.
4. From case 1, iniciar_in with saida_pronto_in held low for 3 cycles, then high -> node 5 (d=10) held stable, then node 7 (d=12), then concluido_out pulse; tem_ativo_out=0 afterwards.
5. During EMITIR, remove a pending node before it is emitted -> it is never presented; concluido_out still arrives; writes are refused during EMITIR.
6. Assert rst_n_in mid-extraction -> all outputs return to reset values immediately, with no concluido_out pulse.
